// File: rtl/imm_encoder.sv
// imm_encoder: multi-cycle inverse of the immediate extender (rotate imm8/rot4 or 24-bit branch word offset)
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic [31:0] value,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] field,
  output logic        ok,
  output logic [1:0]  imm_src_o
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_d;
  logic [31:0] v, p, t, off;
  logic [3:0] rot_cnt;
  logic [1:0] src;
  logic hit, br_ok, fin, res_ok;
  logic [23:0] res_field;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign imm_src_o = src;
  always_comb begin
    t = 32'(({v, v} << {rot_cnt, 1'b0}) >> 32);
    off = v - (p + 32'd8);
    hit = t[31:8] == 24'd0;
    br_ok = off[1:0] == 2'b00 && (&off[31:25] || ~|off[31:25]);
    fin = src[1] || hit || rot_cnt == 4'hf;
    res_ok = src == 2'b10 ? br_ok : src == 2'b11 ? 1'b0 : hit;
    res_field = !res_ok ? 24'd0 : src[1] ? off[25:2] : {12'd0, rot_cnt, t[7:0]};
    state_d = state == IDLE ? (in_valid ? SEARCH : IDLE) :
              state == SEARCH ? (fin ? DONE : SEARCH) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      v <= '0;
      p <= '0;
      src <= '0;
      rot_cnt <= '0;
      field <= '0;
      ok <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && in_valid) begin
        v <= value;
        p <= pc;
        src <= imm_src;
        rot_cnt <= '0;
      end
      if (state == SEARCH) begin
        if (fin) begin
          field <= res_field;
          ok <= res_ok;
        end else rot_cnt <= rot_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench with a brute-force extender model for imm_encoder
module tb_imm_encoder;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [1:0] imm_src = 0;
  logic [31:0] value = 0, pc = 0;
  logic in_ready, out_valid, ok;
  logic [23:0] field;
  logic [1:0] imm_src_o;
  int n_checks = 0, n_fail = 0;
  typedef struct {logic [23:0] f; logic ok; logic [1:0] s; int lat; logic [31:0] v, p;} exp_t;
  exp_t sb[$];

  imm_encoder dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .value(value), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .field(field), .ok(ok), .imm_src_o(imm_src_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Searches the extender's whole input space, so it shares no algorithm with the encoder
  function automatic exp_t model(logic [1:0] s, logic [31:0] v, logic [31:0] p);
    exp_t e;
    logic [31:0] off;
    e.f = 0; e.ok = 0; e.s = s; e.v = v; e.p = p; e.lat = 1;
    off = v - p - 32'd8;
    if (s == 2'b10) begin
      if (off[1:0] == 2'b00 && $signed(off) >= -33554432 && $signed(off) < 33554432) begin
        e.ok = 1; e.f = off[25:2];
      end
    end else if (s != 2'b11) begin
      e.lat = 16;
      for (int r = 15; r >= 0; r--)
        for (int i = 0; i < 256; i++)
          if (ror(32'(i), 2 * r) == v) begin
            e.ok = 1; e.f = {12'd0, 4'(r), 8'(i)}; e.lat = r + 1;
          end
    end
    return e;
  endfunction

  task automatic req(input logic [1:0] s, input logic [31:0] v, input logic [31:0] p, input int hold);
    exp_t e;
    int n;
    logic [31:0] rt;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: in_ready=%b want 1", in_ready); end
    in_valid = 1; imm_src = s; value = v; pc = p;
    sb.push_back(model(s, v, p));
    @(posedge clk); #1;
    in_valid = 0; value = $urandom; pc = $urandom; imm_src = 2'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    n_checks++;
    if (n !== e.lat) begin n_fail++; $display("FAIL latency src=%b v=%h: got %0d want %0d", s, v, n, e.lat); end
    n_checks++;
    if ({field, ok, imm_src_o} !== {e.f, e.ok, e.s}) begin
      n_fail++;
      $display("FAIL result src=%b v=%h pc=%h: field=%h ok=%b src_o=%b want field=%h ok=%b src_o=%b",
               s, v, p, field, ok, imm_src_o, e.f, e.ok, e.s);
    end
    if (ok === 1'b1) begin
      rt = imm_src_o[1] ? {{6{field[23]}}, field, 2'b00} : ror({24'd0, field[7:0]}, 2 * int'(field[11:8]));
      n_checks++;
      if (rt !== (imm_src_o[1] ? e.v - e.p - 32'd8 : e.v)) begin
        n_fail++; $display("FAIL roundtrip src=%b v=%h: extender gave %h", s, v, rt);
      end
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready, field, ok, imm_src_o} !== {1'b1, 1'b0, e.f, e.ok, e.s}) begin
          n_fail++;
          $display("FAIL hold: valid=%b ready=%b field=%h ok=%b want valid=1 ready=0 field=%h ok=%b",
                   out_valid, in_ready, field, ok, e.f, e.ok);
        end
      end
      @(negedge clk); out_ready = 1;
    end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL handshake: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({in_ready, out_valid, field, ok, imm_src_o} !== {1'b1, 1'b0, 24'd0, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL reset: ready=%b valid=%b field=%h ok=%b src_o=%b", in_ready, out_valid, field, ok, imm_src_o);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_rotate;
    req(2'b00, 32'h000000FF, 0, 0);
    req(2'b01, 32'h00000000, 0, 0);
    req(2'b00, 32'hFF000000, 0, 0);
    req(2'b00, 32'h000003FC, 0, 0);
    req(2'b00, 32'h00000101, 0, 0);
    req(2'b01, 32'hC000003F, 0, 0);
  endtask

  task automatic test_branch;
    req(2'b10, 32'h00000200, 32'h100, 0);
    req(2'b10, 32'h00000100, 32'h100, 0);
    req(2'b10, 32'h00000102, 32'h100, 0);
    req(2'b10, 32'h08000108, 32'h100, 0);
    req(2'b10, 32'h02000104, 32'h100, 0);
    req(2'b10, 32'hFE000108, 32'h100, 0);
  endtask

  task automatic test_backpressure;
    @(negedge clk); out_ready = 0;
    req(2'b00, 32'h0000AB00, 0, 10);
    req(2'b11, 32'h00000010, 0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1; imm_src = 2'b00; value = 32'h101;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, field, ok, imm_src_o} !== {1'b1, 1'b0, 24'd0, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL reset_mid: ready=%b valid=%b field=%h ok=%b src_o=%b", in_ready, out_valid, field, ok, imm_src_o);
    end
    @(negedge clk); rst_n = 1;
    req(2'b00, 32'h3F000000, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] p;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0)
        req(2'($urandom_range(0, 1)), $urandom_range(0, 1) ? ror(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15)) : $urandom, 0, 0);
      else begin
        p = $urandom & 32'hFFFFFFFC;
        req(2'b10, p + 32'd8 + ($urandom_range(0, 1) ? {{7{$urandom_range(0, 1) == 1}}, 25'($urandom & 32'h01FFFFFC)} : $urandom), p, 0);
      end
    end
  endtask

  task automatic test_back_to_back;
    req(2'b10, 32'h00001008, 32'h00001000, 0);
    req(2'b10, 32'h00000FF8, 32'h00001000, 0);
    req(2'b00, 32'h00000004, 0, 0);
  endtask

  initial begin
    test_reset;
    test_rotate;
    test_branch;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
# imm_encoder

Multi-cycle immediate encoder: the inverse of the CPU's immediate extender. Given a 32-bit constant and an `ImmSrc` class, it produces the instruction immediate field that the extender expands back to the same value. Data-processing immediates use the 8-bit value / 4-bit rotate form; branch offsets use the 24-bit word-offset form. It sits in the instruction-build path (loader/patcher) ahead of instruction memory and uses valid/ready handshakes on both sides.

## Interface

- No parameters; all widths fixed.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `imm_src`  in  2  00/01 = rotate immediate; 10 = branch; 11 = invalid.
- `value`  in  32  constant (rotate mode) or branch target address (branch mode).
- `pc`  in  32  address of the branch instruction (branch mode only).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `field`  out  24  encoded field: rotate mode `{12'b0, rot[3:0], imm8[7:0]}`; branch mode `offset[25:2]`.
- `ok`  out  1  value is encodable; when 0, `field` = 0.
- `imm_src_o`  out  2  echo of the accepted `imm_src`.

## Operation

- States: IDLE, SEARCH, DONE.
- IDLE: `in_ready`=1. When `in_valid` is high at an edge (E0), the block registers `value`, `pc`, and `imm_src`, clears `rot_cnt` to 0, and enters SEARCH.
- SEARCH, rotate mode: each cycle tests `t = ROL(value, 2*rot_cnt)`, 32-bit and wrapping.
  - `t[31:8]==0`: latch `rot=rot_cnt`, `imm8=t[7:0]`, `ok`=1, go to DONE.
  - Else `rot_cnt==15`: `ok`=0, `field`=0, go to DONE.
  - Else `rot_cnt++`.
- Rotate mode returns the smallest encodable `rot`. A value of 0 encodes as `rot`=0, `imm8`=0.
- SEARCH, branch mode: one cycle. `off = value - (pc + 32'd8)`, modulo 2^32.
  - `ok` = (`off[1:0]==0`) and (`off[31:25]` all equal to `off[25]`), i.e. `off` fits signed 26 bits.
  - `field = ok ? off[25:2] : 0`. Go to DONE.
- SEARCH, `imm_src`=11: one cycle. `ok`=0, `field`=0, go to DONE.
- DONE: `out_valid`=1. `field`, `ok`, and `imm_src_o` are held stable until `out_valid && out_ready` at an edge, then the block goes to IDLE.
- Input signals are ignored outside IDLE. Registered copies isolate the computation from later input changes.
- Round-trip invariant: when `ok`=1, the extender given `Instr[23:0]=field` and `ImmSrc=imm_src_o` returns `value`. In branch mode it returns `value - pc - 8`, sign-extended.

## Timing

- Reset (`rst_n` low, asynchronous, any state, including mid-SEARCH):
  - state = IDLE, so `in_ready`=1;
  - `out_valid`=0, `field`=0, `ok`=0, `imm_src_o`=0, `rot_cnt`=0.
  - Any in-flight request is dropped.
- Rotate latency: `out_valid` rises after edge E(k+1), where k is the found `rot`. An unencodable value gives `out_valid` after E16. Worst case is 16 cycles.
- Branch and invalid latency: `out_valid` after E1.
- No same-cycle turnaround. After the output handshake edge the block is in IDLE, and the next accept happens at the following edge at the earliest. Maximum throughput for branch mode is one request per 3 cycles.
- `out_ready` held low keeps DONE indefinitely with outputs stable.
- `in_valid` asserted during SEARCH or DONE is neither accepted nor lost by the block; the producer must hold it until `in_ready`.

## Test plan

- Rotate, `value`=0x000000FF -> `out_valid` after E1, `field`=0x0000FF, `ok`=1; `value`=0 -> `field`=0x000000, `ok`=1.
- Rotate, `value`=0xFF000000 -> `field`=0x0004FF (`rot`=4), `out_valid` after E5. `value`=0x000003FC -> `field`=0x000FFF (`rot`=15), after E16.
- Rotate, `value`=0x00000101 -> `ok`=0, `field`=0, `out_valid` after E16.
- Branch, `pc`=0x100:
  - `value`=0x200 -> `field`=0x00003E, `ok`=1;
  - `value`=0x100 -> `field`=0xFFFFFE;
  - `value`=0x102 -> `ok`=0;
  - `value`=0x08000108 -> `ok`=0 (out of range);
  - each with `out_valid` after E1.
- Backpressure and handshake: hold `out_ready`=0 for 10 cycles -> outputs stable and `in_ready`=0; release -> IDLE, next request accepted one edge later. `imm_src`=11 -> `ok`=0 after E1.
- Reset mid-SEARCH (`value`=0x101, assert `rst_n`=0 at cycle 5) -> all outputs at reset values immediately and `in_ready`=1. A new request after release completes normally.
- Randomized round-trip: the encoder output is fed to the extender model, with `ok`=1 required exactly when an encoding exists; the result must reproduce `value` (rotate) or `value-pc-8` (branch).
